// File: rtl/seq_matmul_pkg.sv
// Shared types and helpers for the sequential DIMxDIM matrix multiplier.
package seq_matmul_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StCalc = 3'd2,
      StSign = 3'd3,
      StAcc  = 3'd4,
      StDone = 3'd5
   } state_e;

   // Width of the shift-add step counter for a DW-bit operand.
   function automatic int unsigned step_w(input int unsigned dw);
      return $clog2(dw + 1);
   endfunction

   // Flat element index of (row, col) in a row-major packed matrix.
   function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col,
                                            input int unsigned dim);
      return row * dim + col;
   endfunction

endpackage

// File: rtl/seq_mac_lane.sv
// One output-element lane: sign-magnitude load, serial shift-add multiply,
// sign fix-up and AW-bit accumulator of the DIM inner-product terms.
module seq_mac_lane #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 34
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic          step_i,
   input  logic          fix_i,
   input  logic          acc_i,
   input  logic          signed_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [AW-1:0] acc_o
);

   localparam int unsigned PW = 2 * DW + 1;

   logic [DW-1:0] mag_a_q, mag_a_d;
   logic          sign_q, sign_d;
   logic [PW-1:0] prod_q, prod_d;
   logic [AW-1:0] acc_q, acc_d;

   logic [DW-1:0] mag_a_in, mag_b_in;
   logic [DW:0]   sum;
   logic [AW-1:0] prod_ext;

   always_comb begin
      // -2^(DW-1) negates to itself, which is the correct unsigned magnitude.
      mag_a_in = (signed_i && a_i[DW-1]) ? -a_i : a_i;
      mag_b_in = (signed_i && b_i[DW-1]) ? -b_i : b_i;
      sum      = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
      prod_ext = signed_i ? {{(AW-PW){prod_q[PW-1]}}, prod_q} : {{(AW-PW){1'b0}}, prod_q};
   end

   always_comb begin
      mag_a_d = mag_a_q;
      sign_d  = sign_q;
      prod_d  = prod_q;
      acc_d   = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (load_i) begin
         mag_a_d = mag_a_in;
         sign_d  = signed_i & (a_i[DW-1] ^ b_i[DW-1]);
         prod_d  = {{(DW+1){1'b0}}, mag_b_in};
      end else if (step_i) begin
         prod_d = {1'b0, sum, prod_q[DW-1:1]};
      end else if (fix_i) begin
         if (sign_q) prod_d = -prod_q;
      end else if (acc_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mag_a_q <= '0;
         sign_q  <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
      end else begin
         mag_a_q <= mag_a_d;
         sign_q  <= sign_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/seq_matmul_nxn.sv
// DIMxDIM integer matrix multiplier (C = A*B or C += A*B) built from one
// serial MAC lane per output element; the FSM walks k over the inner dimension.
module seq_matmul_nxn
   import seq_matmul_pkg::*;
#(
   parameter int unsigned DW  = 16,
   parameter int unsigned DIM = 2,
   parameter int unsigned AW  = 2 * DW + $clog2(DIM) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic                  acc_mode,
   input  logic [DIM*DIM*DW-1:0] mat_a,
   input  logic [DIM*DIM*DW-1:0] mat_b,
   output logic                  busy,
   output logic                  valid,
   output logic                  ovf,
   output logic [DIM*DIM*AW-1:0] mat_c
);

   localparam int unsigned NE = DIM * DIM;
   localparam int unsigned SW = step_w(DW);
   localparam int unsigned KW = (DIM > 1) ? $clog2(DIM) : 1;

   state_e               state_q, state_d;
   logic [SW-1:0]        step_q, step_d;
   logic [KW-1:0]        k_q, k_d;
   logic [NE*DW-1:0]     a_q, a_d, b_q, b_d;
   logic                 sm_q, sm_d, am_q, am_d;
   logic                 valid_q, valid_d, ovf_q, ovf_d;
   logic [NE*AW-1:0]     c_q, c_d;

   logic                 clr, load, step, fix, acc;
   logic [AW-1:0]        lane_acc [NE];
   logic [NE*AW-1:0]     c_new;
   logic                 ovf_any;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      am_d    = am_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;
      c_d     = c_q;
      clr     = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      acc     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               clr     = 1'b1;
               a_d     = mat_a;
               b_d     = mat_b;
               sm_d    = signed_mode;
               am_d    = acc_mode;
               k_d     = '0;
               state_d = StLoad;
               if (!acc_mode) ovf_d = 1'b0;
            end
         end
         StLoad: begin
            load    = 1'b1;
            step_d  = '0;
            state_d = StCalc;
         end
         StCalc: begin
            step   = 1'b1;
            step_d = step_q + 1'b1;
            if (step_q == SW'(DW - 1)) state_d = StSign;
         end
         StSign: begin
            fix     = 1'b1;
            state_d = StAcc;
         end
         StAcc: begin
            acc = 1'b1;
            if (k_q == KW'(DIM - 1)) begin
               state_d = StDone;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = StLoad;
            end
         end
         StDone: begin
            c_d     = c_new;
            ovf_d   = ovf_q | ovf_any;
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Final write-back: optional add of the stored C with wrap/overflow detection.
   always_comb begin : done_sum
      logic [AW-1:0] old_c;
      logic [AW-1:0] res;
      logic          carry;
      c_new   = '0;
      ovf_any = 1'b0;
      for (int e = 0; e < int'(NE); e++) begin
         old_c        = am_q ? c_q[e*AW +: AW] : '0;
         {carry, res} = {1'b0, lane_acc[e]} + {1'b0, old_c};
         c_new[e*AW +: AW] = res;
         if (am_q) begin
            if (sm_q) begin
               ovf_any = ovf_any | ((lane_acc[e][AW-1] == old_c[AW-1]) &&
                                    (res[AW-1] != old_c[AW-1]));
            end else begin
               ovf_any = ovf_any | carry;
            end
         end
      end
   end

   for (genvar gi = 0; gi < DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < DIM; gj++) begin : g_col
         logic [DW-1:0] a_el, b_el;
         assign a_el = a_q[elem_idx(gi, 32'(k_q), DIM) * DW +: DW];
         assign b_el = b_q[elem_idx(32'(k_q), gj, DIM) * DW +: DW];

         seq_mac_lane #(
            .DW(DW),
            .AW(AW)
         ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr),
            .load_i  (load),
            .step_i  (step),
            .fix_i   (fix),
            .acc_i   (acc),
            .signed_i(sm_q),
            .a_i     (a_el),
            .b_i     (b_el),
            .acc_o   (lane_acc[gi*DIM+gj])
         );
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         step_q  <= '0;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         am_q    <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         am_q    <= am_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         c_q     <= c_d;
      end
   end

   assign busy  = (state_q != StIdle);
   assign valid = valid_q;
   assign ovf   = ovf_q;
   assign mat_c = c_q;

endmodule

// File: tb/tb_seq_matmul_nxn.sv
// Scoreboard bench for seq_matmul_nxn (DW=16, DIM=2): directed operations push
// hand-computed results; a negedge monitor checks each valid pulse.
module tb_seq_matmul_nxn;

   localparam int unsigned DW  = 16;
   localparam int unsigned DIM = 2;
   localparam int unsigned AW  = 34;
   localparam int unsigned N   = DIM * DIM;
   localparam int unsigned CW  = N * AW;
   localparam int          L   = DIM * (DW + 3) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            signed_mode;
   logic            acc_mode;
   logic [N*DW-1:0] mat_a;
   logic [N*DW-1:0] mat_b;
   logic            busy;
   logic            valid;
   logic            ovf;
   logic [CW-1:0]   mat_c;

   typedef struct {
      logic [CW-1:0] c;
      logic          ovf;
      int            due;
      string         name;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   seq_matmul_nxn #(
      .DW (DW),
      .DIM(DIM)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_mode(signed_mode),
      .acc_mode   (acc_mode),
      .mat_a      (mat_a),
      .mat_b      (mat_b),
      .busy       (busy),
      .valid      (valid),
      .ovf        (ovf),
      .mat_c      (mat_c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      logic [N*DW-1:0] r;
      r[0*DW +: DW] = DW'(e0);
      r[1*DW +: DW] = DW'(e1);
      r[2*DW +: DW] = DW'(e2);
      r[3*DW +: DW] = DW'(e3);
      return r;
   endfunction

   function automatic logic [CW-1:0] pc(input longint e0, input longint e1, input longint e2,
                                        input longint e3);
      logic [CW-1:0] r;
      r[0*AW +: AW] = AW'(e0);
      r[1*AW +: AW] = AW'(e1);
      r[2*AW +: AW] = AW'(e2);
      r[3*AW +: AW] = AW'(e3);
      return r;
   endfunction

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_valid: got valid=1 at cycle %0d, expected no result pending",
                     cyc);
         end else begin
            exp_t x;
            x = sb.pop_front();
            for (int e = 0; e < int'(N); e++)
               chk($sformatf("%s.c%0d", x.name, e), CW'(mat_c[e*AW +: AW]),
                   CW'(x.c[e*AW +: AW]));
            chk({x.name, ".ovf"}, CW'(ovf), CW'(x.ovf));
            chk({x.name, ".latency"}, CW'(cyc), CW'(x.due));
            chk({x.name, ".busy"}, CW'(busy), '0);
         end
      end
   end

   // Accepts at the next edge; the DUT is idle there by construction of the sequence.
   task automatic issue(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic sm,
                        input logic am, input logic [CW-1:0] c, input logic ov,
                        input bit expect_it, input string nm);
      mat_a       = a;
      mat_b       = b;
      signed_mode = sm;
      acc_mode    = am;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (expect_it) sb.push_back('{c, ov, cyc + L, nm});
   endtask

   task automatic wait_drain(input string nm);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3 * L) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s.timeout: got %0d results outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N*DW-1:0] a1, b1, a2, m8, ff;
      logic [N*DW-1:0] bb_a [3];
      logic [N*DW-1:0] bb_b [3];
      logic            bb_s [3];
      logic [CW-1:0]   bb_c [3];

      a1 = pk(1, 2, 3, 4);
      b1 = pk(5, 6, 7, 8);
      a2 = pk(-1, 2, 3, -4);
      m8 = pk(-32768, -32768, -32768, -32768);
      ff = pk(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);

      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0;
      mat_a = '0; mat_b = '0;
      #2;
      chk("rst.busy", CW'(busy), '0);
      chk("rst.valid", CW'(valid), '0);
      chk("rst.ovf", CW'(ovf), '0);
      chk("rst.mat_c", mat_c, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      issue(a1, b1, 1'b1, 1'b0, pc(19, 22, 43, 50), 1'b0, 1'b1, "prod");
      wait_drain("prod");
      issue(a1, b1, 1'b1, 1'b1, pc(38, 44, 86, 100), 1'b0, 1'b1, "acc");
      wait_drain("acc");

      issue(a2, m8, 1'b1, 1'b0, pc(-32768, -32768, 32768, 32768), 1'b0, 1'b1, "sedge");
      wait_drain("sedge");
      issue(m8, m8, 1'b1, 1'b0, pc(64'h80000000, 64'h80000000, 64'h80000000, 64'h80000000),
            1'b0, 1'b1, "smin");
      wait_drain("smin");

      issue(ff, ff, 1'b0, 1'b0,
            pc(64'h1FFFC0002, 64'h1FFFC0002, 64'h1FFFC0002, 64'h1FFFC0002), 1'b0, 1'b1, "uns");
      wait_drain("uns");
      issue(ff, ff, 1'b0, 1'b1,
            pc(64'h3FFF80004, 64'h3FFF80004, 64'h3FFF80004, 64'h3FFF80004), 1'b0, 1'b1, "uacc1");
      wait_drain("uacc1");
      issue(ff, ff, 1'b0, 1'b1,
            pc(64'h1FFF40006, 64'h1FFF40006, 64'h1FFF40006, 64'h1FFF40006), 1'b1, 1'b1, "uwrap");
      wait_drain("uwrap");

      // Signed chain 2^31 -> 2^33, which wraps negative in 34 bits.
      issue(m8, m8, 1'b1, 1'b0, pc(64'h80000000, 64'h80000000, 64'h80000000, 64'h80000000),
            1'b0, 1'b1, "sclr");
      wait_drain("sclr");
      issue(m8, m8, 1'b1, 1'b1,
            pc(64'h100000000, 64'h100000000, 64'h100000000, 64'h100000000), 1'b0, 1'b1, "sacc2");
      wait_drain("sacc2");
      issue(m8, m8, 1'b1, 1'b1,
            pc(64'h180000000, 64'h180000000, 64'h180000000, 64'h180000000), 1'b0, 1'b1, "sacc3");
      wait_drain("sacc3");
      issue(m8, m8, 1'b1, 1'b1,
            pc(64'h200000000, 64'h200000000, 64'h200000000, 64'h200000000), 1'b1, 1'b1, "swrap");
      wait_drain("swrap");
      issue(m8, m8, 1'b1, 1'b1,
            pc(64'h280000000, 64'h280000000, 64'h280000000, 64'h280000000), 1'b1, 1'b1, "ssticky");
      wait_drain("ssticky");

      // Reset in the middle of an accumulate while ovf is still set.
      issue(m8, m8, 1'b1, 1'b1, '0, 1'b0, 1'b0, "rstmid");
      repeat (8) @(posedge clk);
      #1;
      chk("rstmid.busy_before", CW'(busy), CW'(1));
      chk("rstmid.ovf_before", CW'(ovf), CW'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid.busy", CW'(busy), '0);
      chk("rstmid.valid", CW'(valid), '0);
      chk("rstmid.ovf", CW'(ovf), '0);
      chk("rstmid.mat_c", mat_c, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(a1, b1, 1'b1, 1'b1, pc(19, 22, 43, 50), 1'b0, 1'b1, "postrst");
      wait_drain("postrst");

      // A start while busy must be dropped, not restart or queue an operation.
      issue(a1, b1, 1'b1, 1'b0, pc(19, 22, 43, 50), 1'b0, 1'b1, "busyign");
      repeat (10) @(posedge clk);
      #1;
      chk("busyign.busy", CW'(busy), CW'(1));
      mat_a = a2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain("busyign");
      repeat (L + 5) @(negedge clk);

      // Start held high; operands change in each valid cycle.
      bb_a[0] = a1; bb_b[0] = b1; bb_s[0] = 1'b1; bb_c[0] = pc(19, 22, 43, 50);
      bb_a[1] = a2; bb_b[1] = b1; bb_s[1] = 1'b1; bb_c[1] = pc(9, 10, -13, -14);
      bb_a[2] = pk(32'hFFFF, 0, 0, 1); bb_b[2] = pk(2, 3, 4, 5); bb_s[2] = 1'b0;
      bb_c[2] = pc(64'h1FFFE, 64'h2FFFD, 4, 5);
      acc_mode = 1'b0;
      start    = 1'b1;
      for (int n = 0; n < 3; n++) begin
         mat_a       = bb_a[n];
         mat_b       = bb_b[n];
         signed_mode = bb_s[n];
         @(posedge clk);
         #1;
         sb.push_back('{bb_c[n], 1'b0, cyc + L, $sformatf("b2b%0d", n)});
         repeat (L) @(posedge clk);
         #1;
      end
      start = 1'b0;
      wait_drain("b2b");
      repeat (L + 5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
